// File: rtl/vga_pkg.sv
// Shared types and constants for the VGA pixel probe.
// Holds the probe FSM state type and the visible-area size.
package vga_pkg;

    localparam logic [10:0] HOR_PIXELS = 11'd800;
    localparam logic [10:0] VER_PIXELS = 11'd600;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        DONE  = 2'd2
    } probe_state_t;

endpackage

// File: rtl/vga_if.sv
// VGA pixel stream bundle: counters, syncs, blanking, colour.
// Modports: in (consumer), out (producer).
interface vga_if;

    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hsync;
    logic        vsync;
    logic        hblnk;
    logic        vblnk;
    logic [11:0] rgb;

    modport in (
        input hcount, vcount,
        input hsync, vsync,
        input hblnk, vblnk,
        input rgb
    );

    modport out (
        output hcount, vcount,
        output hsync, vsync,
        output hblnk, vblnk,
        output rgb
    );

endinterface

// File: rtl/vga_frame_tracker.sv
// Counts frame starts (hcount==0, vcount==0) with a 2-bit saturating count.
// Ports: clk, rst, clear (restart count), hcount, vcount -> frame_cnt.
module vga_frame_tracker (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic [10:0] hcount,
    input  logic [10:0] vcount,
    output logic [1:0]  frame_cnt
);

    logic start;

    assign start = (hcount == '0) && (vcount == '0);

    // clear beats a coincident frame start
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            frame_cnt <= 2'd0;
        end else if (start && (frame_cnt != 2'd3)) begin
            frame_cnt <= frame_cnt + 2'd1;
        end
    end

endmodule

// File: rtl/vga_pixel_probe.sv
// Captures the colour drawn at a requested (x,y) from a VGA pixel stream.
// Ports: clk, rst, in (vga_if.in), probe_req/x/y -> probe_busy, probe_done,
// probe_miss, probe_rgb, and probe_hit when VGA_PROBE_HIT_EN is defined.
module vga_pixel_probe
    import vga_pkg::*;
#(
    parameter logic [11:0] KEY_RGB     = 12'h000,
    parameter int          FRAME_LIMIT = 2
) (
    input  logic        clk,
    input  logic        rst,
    vga_if.in           in,
    input  logic        probe_req,
    input  logic [10:0] probe_x,
    input  logic [10:0] probe_y,
    output logic        probe_busy,
    output logic        probe_done,
    output logic        probe_miss,
    output logic [11:0] probe_rgb
`ifdef VGA_PROBE_HIT_EN
    ,
    output logic        probe_hit
`endif
);

    probe_state_t state;

    logic [10:0] x_q;
    logic [10:0] y_q;
    logic        off_q;
    logic        accept;
    logic        match;
    logic        limit;
    logic [1:0]  frame_cnt;

    assign accept = (state == IDLE) && probe_req;

    // off-screen targets can never match, whatever the blanking says
    assign match = (in.hcount == x_q) &&
                   (in.vcount == y_q) &&
                   !in.hblnk && !in.vblnk &&
                   !off_q;

    // registered count: limit seen the cycle after the frame start
    assign limit = int'(frame_cnt) >= FRAME_LIMIT;

    vga_frame_tracker u_frames (
        .clk       (clk),
        .rst       (rst),
        .clear     (accept),
        .hcount    (in.hcount),
        .vcount    (in.vcount),
        .frame_cnt (frame_cnt)
    );

`ifdef VGA_PROBE_HIT_EN
    logic key_eq;
    logic unused_ok;

    assign key_eq    = (in.rgb == KEY_RGB);
    assign unused_ok = ^{in.hsync, in.vsync};

    always_ff @(posedge clk) begin
        if (rst) begin
            probe_hit <= 1'b0;
        end else if (state == ARMED) begin
            if (match) begin
                probe_hit <= key_eq;
            end else if (limit) begin
                probe_hit <= 1'b0;
            end
        end
    end
`else
    logic unused_ok;

    assign unused_ok = ^{in.hsync, in.vsync, KEY_RGB};
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            x_q        <= '0;
            y_q        <= '0;
            off_q      <= 1'b0;
            probe_busy <= 1'b0;
            probe_done <= 1'b0;
            probe_miss <= 1'b0;
            probe_rgb  <= 12'h000;
        end else begin
            probe_done <= 1'b0;
            unique case (state)
                IDLE: begin
                    probe_busy <= 1'b0;
                    if (probe_req) begin
                        x_q        <= probe_x;
                        y_q        <= probe_y;
                        off_q      <= (probe_x >= HOR_PIXELS) ||
                                      (probe_y >= VER_PIXELS);
                        probe_busy <= 1'b1;
                        state      <= ARMED;
                    end
                end
                ARMED: begin
                    // a match wins over a coincident limit
                    if (match) begin
                        probe_rgb  <= in.rgb;
                        probe_miss <= 1'b0;
                        probe_done <= 1'b1;
                        state      <= DONE;
                    end else if (limit) begin
                        probe_rgb  <= 12'h000;
                        probe_miss <= 1'b1;
                        probe_done <= 1'b1;
                        state      <= DONE;
                    end
                end
                DONE: begin
                    probe_busy <= 1'b0;
                    state      <= IDLE;
                end
                default: begin
                    probe_busy <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vga_pixel_probe.sv
// Randomized and directed bench for vga_pixel_probe.
// Streams are prebuilt in arrays, replayed, and checked per edge.
module tb_vga_pixel_probe;

    localparam int          FL   = 2;
    localparam logic [11:0] KEY  = 12'h0F0;
    localparam int          MAXN = 512;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    vga_if vif ();

    logic        probe_req;
    logic [10:0] probe_x;
    logic [10:0] probe_y;
    logic        probe_busy;
    logic        probe_done;
    logic        probe_miss;
    logic [11:0] probe_rgb;
`ifdef VGA_PROBE_HIT_EN
    logic        probe_hit;
`endif

    vga_pixel_probe #(
        .KEY_RGB     (KEY),
        .FRAME_LIMIT (FL)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in         (vif),
        .probe_req  (probe_req),
        .probe_x    (probe_x),
        .probe_y    (probe_y),
        .probe_busy (probe_busy),
        .probe_done (probe_done),
        .probe_miss (probe_miss),
        .probe_rgb  (probe_rgb)
`ifdef VGA_PROBE_HIT_EN
        ,
        .probe_hit  (probe_hit)
`endif
    );

    int total = 0;
    int bad   = 0;

    int          s_h   [MAXN];
    int          s_v   [MAXN];
    logic [11:0] s_rgb [MAXN];
    bit          s_hb  [MAXN];
    bit          s_vb  [MAXN];
    bit          s_req [MAXN];
    bit          s_rst [MAXN];
    int          s_x   [MAXN];
    int          s_y   [MAXN];

    bit          o_busy [MAXN];
    bit          o_done [MAXN];
    bit          o_miss [MAXN];
    bit          o_hit  [MAXN];
    logic [11:0] o_rgb  [MAXN];

    int          m_d;
    bit          m_miss;
    logic [11:0] m_rgb;

    task automatic set_pix(input int i, input int h, input int v,
                           input logic [11:0] c);
        s_h[i]   = h;
        s_v[i]   = v;
        s_rgb[i] = c;
        s_hb[i]  = (h >= 800);
        s_vb[i]  = (v >= 600);
    endtask

    // background: never a frame start, never either excluded coordinate
    task automatic fill_bg(input int n, input int x, input int y,
                           input int x2, input int y2);
        int h;
        int v;
        for (int i = 0; i < n; i++) begin
            s_req[i] = 1'b0;
            s_rst[i] = 1'b0;
            s_x[i]   = 0;
            s_y[i]   = 0;
            do begin
                h = $urandom_range(0, 1055);
                v = $urandom_range(0, 627);
            end while ((h == x && v == y) || (h == x2 && v == y2) ||
                       (h == 0 && v == 0));
            set_pix(i, h, v, 12'($urandom));
        end
    endtask

    task automatic request(input int i, input int x, input int y);
        s_req[i] = 1'b1;
        s_x[i]   = x;
        s_y[i]   = y;
    endtask

    task automatic play(input int n);
        for (int i = 0; i < n; i++) begin
            rst        = s_rst[i];
            probe_req  = s_req[i];
            probe_x    = 11'(s_x[i]);
            probe_y    = 11'(s_y[i]);
            vif.hcount = 11'(s_h[i]);
            vif.vcount = 11'(s_v[i]);
            vif.hsync  = 1'b0;
            vif.vsync  = 1'b0;
            vif.hblnk  = s_hb[i];
            vif.vblnk  = s_vb[i];
            vif.rgb    = s_rgb[i];
            @(posedge clk);
            #1;
            o_busy[i] = probe_busy;
            o_done[i] = probe_done;
            o_miss[i] = probe_miss;
            o_rgb[i]  = probe_rgb;
`ifdef VGA_PROBE_HIT_EN
            o_hit[i]  = probe_hit;
`else
            o_hit[i]  = 1'b0;
`endif
        end
        probe_req = 1'b0;
        rst       = 1'b0;
    endtask

    // Reference: request accepted at edge a. Each later cycle first
    // looks for the visible target pixel; failing that, if FL frame
    // starts have already been counted (a frame start is counted at
    // its own edge and seen from the next cycle) the probe misses.
    // The result shows on the outputs right after edge m_d.
    task automatic model(input int a, input int x, input int y,
                         input int n);
        int frames;
        frames = 0;
        m_d    = -1;
        m_miss = 1'b0;
        m_rgb  = 12'h000;
        for (int i = a + 1; i < n && m_d < 0; i++) begin
            if (s_h[i] == x && s_v[i] == y && !s_hb[i] && !s_vb[i]) begin
                m_d   = i;
                m_rgb = s_rgb[i];
            end else if (frames >= FL) begin
                m_d    = i;
                m_miss = 1'b1;
            end else if (s_h[i] == 0 && s_v[i] == 0) begin
                frames++;
            end
        end
    endtask

    function automatic int done_count(input int n);
        int c;
        c = 0;
        for (int e = 0; e < n; e++) c += int'(o_done[e]);
        return c;
    endfunction

    task automatic test_reset();
        fill_bg(4, 100, 50, 100, 50);
        s_rst[0] = 1'b1;
        s_rst[1] = 1'b1;
        s_rst[2] = 1'b1;
        request(1, 100, 50);
        play(4);
        total++;
        if (o_busy[2] !== 1'b0) begin
            bad++;
            $display("FAIL rst_busy got=%0b exp=0", o_busy[2]);
        end
        total++;
        if (o_done[2] !== 1'b0) begin
            bad++;
            $display("FAIL rst_done got=%0b exp=0", o_done[2]);
        end
        total++;
        if (o_miss[2] !== 1'b0) begin
            bad++;
            $display("FAIL rst_miss got=%0b exp=0", o_miss[2]);
        end
        total++;
        if (o_rgb[2] !== 12'h000) begin
            bad++;
            $display("FAIL rst_rgb got=%h exp=000", o_rgb[2]);
        end
        total++;
        if (o_hit[2] !== 1'b0) begin
            bad++;
            $display("FAIL rst_hit got=%0b exp=0", o_hit[2]);
        end
        total++;
        if (o_busy[3] !== 1'b0) begin
            bad++;
            $display("FAIL rst_req_ignored got=%0b exp=0", o_busy[3]);
        end
    endtask

    task automatic test_capture();
        fill_bg(40, 100, 50, 100, 50);
        request(0, 100, 50);
        set_pix(20, 100, 50, 12'hF00);
        play(40);
        for (int e = 0; e <= 21; e++) begin
            total++;
            if (o_busy[e] !== (e <= 20)) begin
                bad++;
                $display("FAIL cap_busy e=%0d got=%0b exp=%0b",
                         e, o_busy[e], (e <= 20));
            end
        end
        total++;
        if (done_count(40) !== 1 || o_done[20] !== 1'b1) begin
            bad++;
            $display("FAIL cap_done cnt=%0d at20=%0b exp=1,1",
                     done_count(40), o_done[20]);
        end
        total++;
        if (o_rgb[20] !== 12'hF00 || o_miss[20] !== 1'b0) begin
            bad++;
            $display("FAIL cap_rgb got=%h/%0b exp=F00/0",
                     o_rgb[20], o_miss[20]);
        end
    endtask

    task automatic test_offscreen();
        fill_bg(60, 900, 10, 900, 10);
        request(0, 900, 10);
        set_pix(10, 0, 0, 12'h123);
        set_pix(25, 900, 10, 12'hF00);
        set_pix(40, 0, 0, 12'h456);
        play(60);
        total++;
        if (done_count(60) !== 1 || o_done[41] !== 1'b1) begin
            bad++;
            $display("FAIL off_done cnt=%0d at41=%0b exp=1,1",
                     done_count(60), o_done[41]);
        end
        total++;
        if (o_miss[41] !== 1'b1 || o_rgb[41] !== 12'h000) begin
            bad++;
            $display("FAIL off_miss got=%0b/%h exp=1/000",
                     o_miss[41], o_rgb[41]);
        end
        total++;
        if (o_busy[41] !== 1'b1 || o_busy[42] !== 1'b0) begin
            bad++;
            $display("FAIL off_busy got=%0b%0b exp=10",
                     o_busy[41], o_busy[42]);
        end
    endtask

    task automatic test_origin();
        fill_bg(40, 0, 0, 0, 0);
        request(0, 0, 0);
        set_pix(0, 0, 0, 12'hABC);
        set_pix(30, 0, 0, 12'h5A5);
        play(40);
        total++;
        if (done_count(40) !== 1 || o_done[30] !== 1'b1) begin
            bad++;
            $display("FAIL org_done cnt=%0d at30=%0b exp=1,1",
                     done_count(40), o_done[30]);
        end
        total++;
        if (o_rgb[30] !== 12'h5A5 || o_miss[30] !== 1'b0) begin
            bad++;
            $display("FAIL org_rgb got=%h/%0b exp=5A5/0",
                     o_rgb[30], o_miss[30]);
        end
    endtask

    task automatic test_back_to_back();
        bit any_busy;
        fill_bg(50, 5, 5, 200, 300);
        request(0, 5, 5);
        request(3, 200, 300);
        set_pix(8, 200, 300, 12'h111);
        request(10, 200, 300);
        set_pix(15, 5, 5, 12'h777);
        request(16, 200, 300);
        set_pix(30, 200, 300, 12'h222);
        set_pix(35, 0, 0, 12'h000);
        set_pix(40, 0, 0, 12'h000);
        play(50);
        total++;
        if (done_count(50) !== 1 || o_done[15] !== 1'b1) begin
            bad++;
            $display("FAIL b2b_done cnt=%0d at15=%0b exp=1,1",
                     done_count(50), o_done[15]);
        end
        total++;
        if (o_rgb[15] !== 12'h777) begin
            bad++;
            $display("FAIL b2b_rgb got=%h exp=777", o_rgb[15]);
        end
        any_busy = 1'b0;
        for (int e = 17; e < 50; e++) any_busy |= o_busy[e];
        total++;
        if (any_busy !== 1'b0) begin
            bad++;
            $display("FAIL b2b_queued got=%0b exp=0", any_busy);
        end
    endtask

    task automatic test_reset_abort();
        bit any_busy;
        fill_bg(30, 50, 60, 50, 60);
        request(0, 50, 60);
        s_rst[5] = 1'b1;
        set_pix(10, 50, 60, 12'h321);
        play(30);
        total++;
        if (o_busy[4] !== 1'b1 || o_busy[5] !== 1'b0) begin
            bad++;
            $display("FAIL abort_busy got=%0b%0b exp=10",
                     o_busy[4], o_busy[5]);
        end
        any_busy = 1'b0;
        for (int e = 5; e < 30; e++) any_busy |= o_busy[e];
        total++;
        if (done_count(30) !== 0 || any_busy !== 1'b0) begin
            bad++;
            $display("FAIL abort_done cnt=%0d busy=%0b exp=0,0",
                     done_count(30), any_busy);
        end
        fill_bg(20, 50, 60, 50, 60);
        request(0, 50, 60);
        set_pix(7, 50, 60, 12'h456);
        play(20);
        total++;
        if (done_count(20) !== 1 || o_done[7] !== 1'b1 ||
            o_rgb[7] !== 12'h456) begin
            bad++;
            $display("FAIL abort_retry cnt=%0d at7=%0b rgb=%h exp=1,1,456",
                     done_count(20), o_done[7], o_rgb[7]);
        end
    endtask

    task automatic test_random();
        int x;
        int y;
        int r;
        bit exp_hit;
        for (int k = 0; k < 12; k++) begin
            if (k[0]) begin
                x = $urandom_range(0, 1055);
                y = $urandom_range(0, 627);
            end else begin
                x = $urandom_range(0, 799);
                y = $urandom_range(0, 599);
            end
            fill_bg(210, x, y, x, y);
            for (int i = 1; i < 210; i++) begin
                r = $urandom_range(0, 99);
                if (r < 3) begin
                    set_pix(i, 0, 0, 12'($urandom));
                end else if (r < 7) begin
                    set_pix(i, x, y, r[0] ? KEY : 12'($urandom));
                end else if (r < 9) begin
                    set_pix(i, x, y, 12'($urandom));
                    s_hb[i] = 1'b1;
                end
            end
            set_pix(100, 0, 0, 12'h0AA);
            set_pix(200, 0, 0, 12'h0BB);
            request(0, x, y);
            play(210);
            model(0, x, y, 210);
            total++;
            if (done_count(210) !== 1 || m_d < 0 ||
                o_done[m_d < 0 ? 0 : m_d] !== 1'b1) begin
                bad++;
                $display("FAIL rnd_done k=%0d cnt=%0d exp_edge=%0d",
                         k, done_count(210), m_d);
            end else begin
                total++;
                if (o_miss[m_d] !== m_miss || o_rgb[m_d] !== m_rgb) begin
                    bad++;
                    $display("FAIL rnd_data k=%0d got=%0b/%h exp=%0b/%h",
                             k, o_miss[m_d], o_rgb[m_d], m_miss, m_rgb);
                end
                total++;
                if (o_busy[m_d] !== 1'b1 || o_busy[m_d + 1] !== 1'b0) begin
                    bad++;
                    $display("FAIL rnd_busy k=%0d got=%0b%0b exp=10",
                             k, o_busy[m_d], o_busy[m_d + 1]);
                end
                total++;
                if (o_rgb[209] !== m_rgb) begin
                    bad++;
                    $display("FAIL rnd_hold k=%0d got=%h exp=%h",
                             k, o_rgb[209], m_rgb);
                end
`ifdef VGA_PROBE_HIT_EN
                exp_hit = !m_miss && (m_rgb == KEY);
                total++;
                if (o_hit[m_d] !== exp_hit) begin
                    bad++;
                    $display("FAIL rnd_hit k=%0d got=%0b exp=%0b",
                             k, o_hit[m_d], exp_hit);
                end
`else
                exp_hit = 1'b0;
`endif
            end
        end
    endtask

`ifdef VGA_PROBE_HIT_EN
    task automatic test_hit();
        fill_bg(20, 10, 10, 10, 10);
        request(0, 10, 10);
        set_pix(5, 10, 10, 12'h0F0);
        play(20);
        total++;
        if (o_done[5] !== 1'b1 || o_hit[5] !== 1'b1) begin
            bad++;
            $display("FAIL hit_green done=%0b hit=%0b exp=1,1",
                     o_done[5], o_hit[5]);
        end
        fill_bg(20, 20, 20, 20, 20);
        request(0, 20, 20);
        set_pix(5, 20, 20, 12'hF00);
        play(20);
        total++;
        if (o_done[5] !== 1'b1 || o_hit[5] !== 1'b0) begin
            bad++;
            $display("FAIL hit_red done=%0b hit=%0b exp=1,0",
                     o_done[5], o_hit[5]);
        end
        fill_bg(20, 900, 0, 900, 0);
        request(0, 900, 0);
        set_pix(3, 0, 0, 12'h0F0);
        set_pix(6, 0, 0, 12'h0F0);
        play(20);
        total++;
        if (o_done[7] !== 1'b1 || o_miss[7] !== 1'b1 ||
            o_hit[7] !== 1'b0) begin
            bad++;
            $display("FAIL hit_miss done=%0b miss=%0b hit=%0b exp=1,1,0",
                     o_done[7], o_miss[7], o_hit[7]);
        end
    endtask
`endif

    initial begin
        rst        = 1'b1;
        probe_req  = 1'b0;
        probe_x    = '0;
        probe_y    = '0;
        test_reset();
        test_capture();
        test_offscreen();
        test_origin();
        test_back_to_back();
        test_reset_abort();
        test_random();
`ifdef VGA_PROBE_HIT_EN
        test_hit();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vga_pixel_probe.md
VGA_PIXEL_PROBE -- requirements
Module: vga_pixel_probe

Interface
REQ-001 SHALL have parameter KEY_RGB, default 12'h000: key colour for hit detection (used only with VGA_PROBE_HIT_EN).
REQ-002 SHALL have parameter FRAME_LIMIT, default 2: number of frame starts tolerated while armed before a miss is reported.
REQ-003 SHALL have port clk  input  1  pixel clock; the block has one clock only.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in  vga_if.in  bundle  drawn pixel stream: hcount, vcount, hsync, vsync, hblnk, vblnk, rgb[11:0].
REQ-006 SHALL have port probe_req  input  1  request strobe; sampled in IDLE only.
REQ-007 SHALL have port probe_x  input  11  requested column; latched with probe_req.
REQ-008 SHALL have port probe_y  input  11  requested row; latched with probe_req.
REQ-009 SHALL have port probe_busy  output  1  high from the cycle after an accepted request until the cycle after done.
REQ-010 SHALL have port probe_done  output  1  one-cycle completion pulse.
REQ-011 SHALL have port probe_miss  output  1  valid with probe_done; coordinate never observed as a visible pixel.
REQ-012 SHALL have port probe_rgb  output  12  captured colour; valid with probe_done, held until the next done.
REQ-013 SHALL have port probe_hit  output  1  valid with probe_done; present only with VGA_PROBE_HIT_EN.

Function
REQ-014 SHALL implement FSM IDLE -> ARMED -> DONE -> IDLE.
REQ-015 IDLE: probe_req=1 SHALL latch probe_x/probe_y and move to ARMED on the next edge; other inputs ignored.
REQ-016 ARMED: SHALL capture in.rgb in the cycle where in.hcount==x, in.vcount==y, in.hblnk==0 and in.vblnk==0, then go to DONE.
REQ-017 ARMED: frame start = in.hcount==0 and in.vcount==0; SHALL count frame starts in a 2-bit saturating counter cleared on arming.
REQ-018 ARMED: if the count reaches FRAME_LIMIT with no capture, SHALL go to DONE with miss=1 and rgb=12'h000.
REQ-019 If a match and the limiting frame start occur in the same cycle, match SHALL win (miss=0).
REQ-020 DONE: probe_done=1 for exactly one cycle, then IDLE; busy SHALL drop in that same cycle.
REQ-021 Latency SHALL be exactly one cycle from the matching input pixel to probe_done.
REQ-022 probe_req while ARMED or DONE SHALL be ignored and not queued.
REQ-023 Coordinates outside the visible area (x>=800 or y>=600) SHALL be accepted and end in a miss.
REQ-024 All outputs SHALL be registered; the module does not forward or alter the stream.

Reset
REQ-025 On rst=1 at a rising clk edge: state=IDLE, frame counter=0, busy=0, done=0, miss=0, hit=0, rgb=12'h000, latched x/y=0.
REQ-026 Reset mid-operation SHALL abort the probe with no done pulse.

Configuration
REQ-027 With VGA_PROBE_HIT_EN defined: probe_hit = (captured rgb == KEY_RGB) && !miss, registered with done; used for game collision tests.
REQ-028 Without VGA_PROBE_HIT_EN: probe_hit port and comparator SHALL be absent; all other behaviour is unchanged.

Structure
REQ-029 vga_pkg SHALL hold the probe state enum typedef (IDLE/ARMED/DONE) and the constants HOR_PIXELS=800 and VER_PIXELS=600.
REQ-030 Frame-start detection and saturating counting SHALL live in sub-module vga_frame_tracker (clk, rst, clear, hcount, vcount -> frame_cnt).

Verification (800x600 timing, 1056x628 totals)
REQ-031 Request at (100,50), pixel rgb 12'hF00 at that position -> done exactly one cycle after that pixel, rgb=12'hF00, miss=0.
REQ-032 Request at (900,10) -> done after the second frame start, miss=1, rgb=12'h000.
REQ-033 Request at (0,0) issued during the pixel (0,0) cycle -> capture occurs in the following frame, not the current one.
REQ-034 Second probe_req while busy -> ignored; exactly one done per accepted request.
REQ-035 rst asserted while ARMED -> busy=0 next cycle, no done; a new request afterwards completes normally.
REQ-036 With VGA_PROBE_HIT_EN and KEY_RGB=12'h0F0: green pixel probed -> hit=1; red pixel -> hit=0; miss -> hit=0.
